fp_addsub_seq: RTL and testbench
================================

Name: fp_addsub_seq

Overview:
- Multi-cycle sequencer for IEEE-754 single-precision add/subtract in the 32-bit FP ALU.
- Latches two operands on a START handshake, then steps through unpack, serial alignment, add/sub, normalise and pack.
- Normalise step instantiates the existing 24-bit leading-one normalisation unit:
  - inputs: 24-bit mantissa and carry/overflow flag
  - outputs: 23-bit fraction, 8-bit two's-complement exponent adjust, zero flag
- RESULT, ZERO and OVF go to the ALU result mux.

Parameters:
- ALIGN_CAP, 25: maximum right-shifts applied to the smaller mantissa. Larger exponent differences saturate to this value.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- A  input  32  operand A, IEEE-754 single
- B  input  32  operand B, IEEE-754 single
- SUB  input  1  1 = A-B, 0 = A+B; latched with operands
- BUSY  output  1  high from UNPACK through NORM
- DONE  output  1  one-cycle pulse, RESULT valid
- RESULT  output  32  packed result; held until next NORM
- ZERO  output  1  result is zero (cancellation or underflow flush)
- OVF  output  1  exponent overflow or Inf/NaN input

Behaviour:
- Reset (async, any state): state to IDLE; BUSY, DONE, RESULT, ZERO and OVF all 0; internal registers cleared; any in-flight operation is discarded with no DONE.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, DONE.
- IDLE:
  - START=1 latches A, B and effective sign sB = B[31]^SUB, then goes to UNPACK.
  - START in any other state is ignored; no queueing.
- UNPACK, 1 cycle:
  - Mantissa = {exp!=0, frac}. exp==0 operands (zero/denormal) are flushed to mantissa 0.
  - Compare {exp,frac}. The larger-magnitude operand becomes L; ties make A the L operand.
  - diff = expL-expS; k = min(diff, ALIGN_CAP); clear shift counter.
  - If either exponent == 8'hFF: RESULT = {sign of first such operand (A first), 8'hFF, 23'b0}, OVF=1, ZERO=0, go directly to DONE.
- ALIGN:
  - If counter == k, go to ADD.
  - Otherwise shift mS right by 1 (zero fill, bits discarded) and increment counter.
  - Occupies k+1 cycles.
- ADD, 1 cycle:
  - If sL == sS, sum = mL+mS as 25 bits (carry in bit 24); otherwise sum = mL-mS, which is never negative.
  - Result sign = sL.
- NORM, 1 cycle:
  - Drive the normaliser with IN = sum[23:0] and overflow flag = sum[24].
  - Compute e = expL + sign-extended COUNT in 10-bit signed arithmetic.
  - If zero flag: RESULT=32'h0 (+0), ZERO=1.
  - Else if e >= 255: RESULT = {sign, 8'hFF, 23'b0}, OVF=1.
  - Else if e <= 0: RESULT = {sign, 31'b0}, ZERO=1.
  - Else RESULT = {sign, e[7:0], OUT}.
  - ZERO and OVF are written every NORM; flags not set above are cleared.
  - Rounding is truncation.
- DONE, 1 cycle: DONE=1, BUSY=0, then return to IDLE. A new START is accepted in the following IDLE cycle.
- Latency, with START sampled at edge 0:
  - UNPACK at cycle 1, ALIGN at cycles 2..2+k, ADD at 3+k, NORM at 4+k.
  - DONE is high during cycle 5+k.
  - Special-value path: DONE high during cycle 2.
- RESULT, ZERO and OVF are stable from DONE until the next NORM or special-value UNPACK.

Test Plan:
- 1.0+1.0: A=3F800000, B=3F800000, SUB=0 -> RESULT=40000000, ZERO=0, OVF=0, DONE in cycle 5, BUSY high cycles 1-4.
- Cancellation: A=3F800000, B=3F800000, SUB=1 -> RESULT=00000000, ZERO=1. Then 1.0-0.75 (B=3F400000, diff 1) -> RESULT=3E800000, DONE in cycle 6.
- Alignment: A=3FC00000 (1.5), B=3E800000 (0.25), SUB=0 -> RESULT=3FE00000, DONE in cycle 7. Swapped operands give the same result and timing.
- Alignment cap: A=3F800000, B=30800000 (2^-30) -> k=25, RESULT=3F800000, DONE in cycle 30.
- Overflow and specials:
  - A=B=7F7FFFFF, SUB=0 -> RESULT=7F800000, OVF=1.
  - A=7F800000, B=3F800000 -> RESULT=7F800000, OVF=1, DONE in cycle 2.
- Control:
  - START pulsed while BUSY is ignored; RESULT matches only the first operation.
  - RST asserted mid-ALIGN immediately drives BUSY, DONE, RESULT and flags to 0; no DONE follows.
  - A START after reset completes normally.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer with truncating rounding.
// Operands are latched on start, aligned one bit per cycle, then summed, normalised and packed.

module fp_norm24 (
    input  logic [23:0] in_i,
    input  logic        ovf_i,
    output logic [22:0] out_o,
    output logic [7:0]  count_o,
    output logic        zero_o
);
    logic [4:0]  lead_pos;
    logic [4:0]  shamt;
    logic [23:0] shifted;

    // The highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        lead_pos = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (in_i[i]) begin
                lead_pos = i[4:0];
            end
        end
    end

    assign shamt   = 5'd23 - lead_pos;
    assign shifted = in_i << shamt;

    always_comb begin
        out_o   = shifted[22:0];
        count_o = 8'd0 - {3'd0, shamt};
        zero_o  = (in_i == 24'd0);
        if (ovf_i) begin
            out_o   = in_i[23:1];
            count_o = 8'd1;
            zero_o  = 1'b0;
        end
    end
endmodule

module fp_addsub_seq #(
    parameter int ALIGN_CAP = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        ovf_o
);
    localparam int         CW   = $clog2(ALIGN_CAP + 1);
    localparam logic [7:0] CAP8 = 8'(ALIGN_CAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   a_q, b_q;
    logic          sb_q;
    logic [23:0]   ml_q, ms_q;
    logic [7:0]    expl_q;
    logic          sl_q, ss_q;
    logic [CW-1:0] k_q, cnt_q;
    logic [24:0]   sum_q;
    logic [31:0]   result_q;
    logic          zero_q, ovf_q;

    logic [7:0]    exp_a, exp_b, diff;
    logic [23:0]   man_a, man_b;
    logic          a_is_l, special, special_sign;
    logic [CW-1:0] k_d;
    logic [24:0]   sum_d;
    logic [22:0]   norm_out;
    logic [7:0]    norm_count;
    logic          norm_zero;
    logic [9:0]    exp_res;
    logic          exp_ovf, exp_unf;

    assign exp_a  = a_q[30:23];
    assign exp_b  = b_q[30:23];
    assign man_a  = (exp_a != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
    assign man_b  = (exp_b != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
    assign a_is_l = (a_q[30:0] >= b_q[30:0]);
    assign diff   = a_is_l ? (exp_a - exp_b) : (exp_b - exp_a);
    assign k_d    = (diff > CAP8) ? CAP8[CW-1:0] : diff[CW-1:0];

    assign special      = (exp_a == 8'hFF) || (exp_b == 8'hFF);
    assign special_sign = (exp_a == 8'hFF) ? a_q[31] : sb_q;

    // Magnitude ordering guarantees the subtraction never goes negative.
    assign sum_d = (sl_q == ss_q) ? ({1'b0, ml_q} + {1'b0, ms_q})
                                  : ({1'b0, ml_q} - {1'b0, ms_q});

    fp_norm24 u_norm (
        .in_i    (sum_q[23:0]),
        .ovf_i   (sum_q[24]),
        .out_o   (norm_out),
        .count_o (norm_count),
        .zero_o  (norm_zero)
    );

    assign exp_res = {2'b00, expl_q} + {{2{norm_count[7]}}, norm_count};
    assign exp_ovf = !exp_res[9] && (exp_res >= 10'd255);
    assign exp_unf = exp_res[9] || (exp_res == 10'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                busy_o  = 1'b1;
                state_d = special ? S_DONE : S_ALIGN;
            end
            S_ALIGN: begin
                busy_o = 1'b1;
                if (cnt_q == k_q) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                busy_o  = 1'b1;
                state_d = S_NORM;
            end
            S_NORM: begin
                busy_o  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sb_q     <= 1'b0;
            ml_q     <= 24'd0;
            ms_q     <= 24'd0;
            expl_q   <= 8'd0;
            sl_q     <= 1'b0;
            ss_q     <= 1'b0;
            k_q      <= '0;
            cnt_q    <= '0;
            sum_q    <= 25'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q  <= a_i;
                        b_q  <= b_i;
                        sb_q <= b_i[31] ^ sub_i;
                    end
                end
                S_UNPACK: begin
                    ml_q   <= a_is_l ? man_a : man_b;
                    ms_q   <= a_is_l ? man_b : man_a;
                    expl_q <= a_is_l ? exp_a : exp_b;
                    sl_q   <= a_is_l ? a_q[31] : sb_q;
                    ss_q   <= a_is_l ? sb_q : a_q[31];
                    k_q    <= k_d;
                    cnt_q  <= '0;
                    if (special) begin
                        result_q <= {special_sign, 8'hFF, 23'd0};
                        ovf_q    <= 1'b1;
                        zero_q   <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    if (cnt_q != k_q) begin
                        ms_q  <= ms_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ADD: begin
                    sum_q <= sum_d;
                end
                S_NORM: begin
                    if (norm_zero) begin
                        result_q <= 32'd0;
                        zero_q   <= 1'b1;
                        ovf_q    <= 1'b0;
                    end else if (exp_ovf) begin
                        result_q <= {sl_q, 8'hFF, 23'd0};
                        zero_q   <= 1'b0;
                        ovf_q    <= 1'b1;
                    end else if (exp_unf) begin
                        result_q <= {sl_q, 31'd0};
                        zero_q   <= 1'b1;
                        ovf_q    <= 1'b0;
                    end else begin
                        result_q <= {sl_q, exp_res[7:0], norm_out};
                        zero_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases plus random operands against an arithmetic reference.

module tb_fp_addsub_seq;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, sub_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o, zero_o, ovf_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    fp_addsub_seq #(.ALIGN_CAP(25)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .sub_i    (sub_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value-level arithmetic on integer mantissas, truncated.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                             output logic [31:0] r, output logic z, output logic o,
                             output int lat);
        int ea, eb, ma, mb, el, es, ml, ms, diff, k, sum, p, e, mant;
        logic sa, sbe, sl, ss;
        logic [7:0]  e8;
        logic [31:0] mant_v;
        sa  = a[31];
        sbe = b[31] ^ s;
        ea  = {24'd0, a[30:23]};
        eb  = {24'd0, b[30:23]};
        if (ea == 255 || eb == 255) begin
            r   = {(ea == 255) ? sa : sbe, 8'hFF, 23'd0};
            z   = 1'b0;
            o   = 1'b1;
            lat = 2;
            return;
        end
        ma = (ea != 0) ? ({9'd0, a[22:0]} + (1 << 23)) : 0;
        mb = (eb != 0) ? ({9'd0, b[22:0]} + (1 << 23)) : 0;
        if (a[30:0] >= b[30:0]) begin
            el = ea; es = eb; ml = ma; ms = mb; sl = sa;  ss = sbe;
        end else begin
            el = eb; es = ea; ml = mb; ms = ma; sl = sbe; ss = sa;
        end
        diff = el - es;
        k    = (diff > 25) ? 25 : diff;
        ms   = ms >> k;
        sum  = (sl == ss) ? (ml + ms) : (ml - ms);
        lat  = 5 + k;
        o    = 1'b0;
        z    = 1'b0;
        if (sum == 0) begin
            r = 32'd0;
            z = 1'b1;
            return;
        end
        p = 0;
        for (int i = 0; i < 25; i++) begin
            if (sum >= (1 << i)) p = i;
        end
        e = el + p - 23;
        if (e >= 255) begin
            r = {sl, 8'hFF, 23'd0};
            o = 1'b1;
        end else if (e <= 0) begin
            r = {sl, 31'd0};
            z = 1'b1;
        end else begin
            mant   = (p >= 23) ? (sum >> (p - 23)) : (sum << (23 - p));
            mant_v = mant;
            e8     = e[7:0];
            r      = {sl, e8, mant_v[22:0]};
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic ez,
                          input logic eo, input int elat, input bit interfere);
        int cyc;
        bit busy_ok;
        @(posedge clk_i); #1;
        a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done_o && cyc < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            if (interfere && cyc == 2) begin
                a_i = 32'h40400000; b_i = 32'h40400000; sub_i = 1'b0; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        start_i = 1'b0;
        $display("op %s a=%h b=%h sub=%0d -> result=%h zero=%0d ovf=%0d done_cycle=%0d",
                 name, a, b, s, result_o, zero_o, ovf_o, cyc);
        check({name, ".done_cycle"}, cyc, elat);
        check({name, ".busy_during"}, 32'(busy_ok), 32'd1);
        check({name, ".result"}, result_o, er);
        check({name, ".zero"}, 32'(zero_o), 32'(ez));
        check({name, ".ovf"}, 32'(ovf_o), 32'(eo));
        check({name, ".busy_at_done"}, 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        check({name, ".done_pulse"}, 32'(done_o), 32'd0);
        check({name, ".idle_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        rs, ez, eo;
        int          lat, done_seen;

        rst_i = 1'b1; start_i = 1'b0; a_i = 32'd0; b_i = 32'd0; sub_i = 1'b0;
        #2;
        check("reset.busy", 32'(busy_o), 32'd0);
        check("reset.done", 32'(done_o), 32'd0);
        check("reset.result", result_o, 32'd0);
        check("reset.zero", 32'(zero_o), 32'd0);
        check("reset.ovf", 32'(ovf_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 5, 1'b0);
        run_op("cancel",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0, 5, 1'b0);
        run_op("one_minus_075",32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 6, 1'b0);
        run_op("align",        32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0, 1'b0, 7, 1'b0);
        run_op("align_swap",   32'h3E800000, 32'h3FC00000, 1'b0, 32'h3FE00000, 1'b0, 1'b0, 7, 1'b0);
        run_op("align_cap",    32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 30, 1'b0);
        run_op("start_busy",   32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0, 1'b0, 7, 1'b1);
        run_op("inf_input",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 2, 1'b0);
        run_op("exp_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 5, 1'b0);

        // Abort a long alignment: RESULT/OVF hold the overflow above until reset clears them.
        @(posedge clk_i); #1;
        a_i = 32'h3F800000; b_i = 32'h30800000; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        check("abort.busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort.busy", 32'(busy_o), 32'd0);
        check("abort.done", 32'(done_o), 32'd0);
        check("abort.result", result_o, 32'd0);
        check("abort.zero", 32'(zero_o), 32'd0);
        check("abort.ovf", 32'(ovf_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) done_seen++;
        end
        $display("op abort_mid_align activity_after_reset=%0d", done_seen);
        check("abort.no_done", done_seen, 32'd0);

        run_op("after_reset",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            ra[30:23] = 8'($urandom_range(100, 150));
            rb[30:23] = 8'($urandom_range(100, 150));
            if (n % 5 == 1) begin
                rb[30:23] = ra[30:23];
                rb[22:8]  = ra[22:8];
            end
            if (n % 9 == 2) rb[30:23] = 8'd0;
            if (n % 11 == 3) begin
                ra[30:23] = 8'd254;
                rb[30:23] = 8'($urandom_range(250, 254));
            end
            if (n % 13 == 4) ra[30:23] = 8'd255;
            if (n % 7 == 5) begin
                ra[30:23] = 8'd1;
                rb[30:23] = 8'd1;
            end
            ref_model(ra, rb, rs, er, ez, eo, lat);
            run_op($sformatf("rand%0d", n), ra, rb, rs, er, ez, eo, lat, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
